ram_sdp_clr: RTL and testbench
==============================

Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM. Successor to the 16x8 asynchronous single-port model memory.
- Adds a clock, independent read and write ports, and a registered read with a valid flag.
- Adds a selectable read-during-write mode and an automatic clear sweep after reset.
- Used as the memory model under test benches and as a scratch buffer in datapath exercises.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width in bits.
- DEPTH, 16: number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- INIT_VAL, 0: value written to every word during the clear sweep; DATA_W bits.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data (read-first), 1 = new data (write-through).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata is valid this cycle.
- busy  out  1  clear sweep in progress; all requests are ignored.
- err  out  1  one-cycle pulse: out-of-range access, or request issued while busy.

Behaviour:
- Reset. The interface is single clock; reset is synchronous and active-high. With rst high at an edge:
  - FSM goes to CLEAR and the sweep counter to 0.
  - Outputs: rdata=0, rvalid=0, busy=1, err=0.
  - Array contents are not touched by rst itself.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes INIT_VAL to mem[cnt] and increments cnt. When cnt==DEPTH-1 is written, the next state is IDLE and busy drops.
  - The sweep therefore takes exactly DEPTH cycles after rst deasserts. busy is 1 for those DEPTH cycles.
  - IDLE: normal operation. rst in any state restarts CLEAR with cnt=0, including mid-sweep.
- Requests during CLEAR:
  - we and re are ignored; memory is not written from the ports and rvalid stays 0.
  - err pulses for 1 cycle if we or re is high.
- Write in IDLE: we=1 and waddr<DEPTH writes mem[waddr]=wdata at that edge.
- Read in IDLE:
  - re=1 and raddr<DEPTH at edge N gives rdata=mem[raddr] and rvalid=1 after edge N. Latency is 1 cycle.
  - rvalid is high for exactly one cycle per accepted read.
  - With no read, rvalid=0 and rdata holds its last value.
- Out of range (DEPTH < 2**ADDR_W): an address >= DEPTH is a no-op.
  - A write to such an address is dropped.
  - A read from such an address returns rdata=0 with rvalid=1.
  - err pulses for 1 cycle; if both ports are out of range, still a single pulse.
- Same-address read and write in one cycle (re, we, raddr==waddr):
  - RDW_MODE=0: rdata = pre-write content.
  - RDW_MODE=1: rdata = wdata.
  - Different addresses: fully independent.
- Back-to-back reads: one per cycle, no bubbles.
- Widths: cnt is ADDR_W+1 bits so that DEPTH = 2**ADDR_W terminates without wrap. No other arithmetic.

Decomposition:
- Shared package `mem_pkg`:
  - FSM state encoding: CLEAR=1'b0, IDLE=1'b1.
  - RDW_READ_FIRST=0 and RDW_WRITE_THROUGH=1 constants.
- One natural sub-module, `ram_sdp_core`:
  - Bare array with one write port and one registered read port, parametrised on DATA_W, DEPTH and RDW_MODE.
  - The top keeps the clear FSM, the write-port mux (sweep vs user), range checks, err and rvalid.

Test Plan:
- Defaults, INIT_VAL=8'hA5. Pulse rst 1 cycle, then read all 16 addresses once busy=0.
  - busy=1 for exactly 16 cycles.
  - Every read returns 8'hA5 with rvalid=1, one cycle after re.
- Write data=2*k to addr=k for k=0..15, then read a random address sequence (seed 35) for 20 reads.
  - Each rdata == 2*addr, 1 cycle after re.
  - rvalid is high on every one of the 20 cycles.
- Write 8'h11 to addr 3. Then in the same cycle write 8'h22 to addr 3 and read addr 3.
  - RDW_MODE=0: rdata=8'h11.
  - RDW_MODE=1: rdata=8'h22.
  - Next read of addr 3 returns 8'h22 in both modes.
- DEPTH=12, ADDR_W=4. Write 8'h5A to addr 13, then read addr 13.
  - err pulses on each request.
  - rdata=0 with rvalid=1; mem[0..11] unchanged.
- Assert rst again at sweep cycle 7, and hold we=1 throughout the sweep.
  - busy stays 1 for 16 cycles after the second rst.
  - err is high each cycle we=1 is held.
  - All words read back as INIT_VAL.
- Assert rst in the same cycle as a read request.
  - Next cycle: rvalid=0, rdata=0, busy=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the simple-dual-port clearing RAM.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int RDW_READ_FIRST    = 0;
    localparam int RDW_WRITE_THROUGH = 1;

endpackage

// File: rtl/ram_sdp_clr_if.sv
// Request/response bundle between a requester and ram_sdp_clr.
interface ram_sdp_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;
    logic              err;

    modport master (
        output we, waddr, wdata, re, raddr,
        input  rdata, rvalid, busy, err
    );

    modport slave (
        input  we, waddr, wdata, re, raddr,
        output rdata, rvalid, busy, err
    );
endinterface

// File: rtl/ram_sdp_core.sv
// Bare storage array: one write port, one registered read port with
// selectable same-address read-during-write behaviour.
module ram_sdp_core
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_bypass;

    assign w_bypass = (RDW_MODE == RDW_WRITE_THROUGH) && i_we && (i_waddr == i_raddr);

    // Storage has no reset; contents survive rst and are rewritten by the sweep.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rzero) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_bypass ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with post-reset clear sweep, range checking and
// a one-cycle error pulse for rejected or out-of-range requests.
module ram_sdp_clr
    import mem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int                RDW_MODE = RDW_READ_FIRST
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ram_sdp_clr_if.slave  bus
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

    state_t          r_state, w_state_nx;
    logic [ADDR_W:0] r_cnt, w_cnt_nx;
    logic            r_rvalid;
    logic            r_err;

    logic              w_idle;
    logic              w_wr_in, w_rd_in;
    logic              w_wr_oor, w_rd_oor;
    logic              w_core_we;
    logic [ADDR_W-1:0] w_core_waddr;
    logic [DATA_W-1:0] w_core_wdata;
    logic              w_core_re;
    logic              w_core_rzero;

    assign w_idle   = (r_state == IDLE);
    assign w_wr_in  = ({1'b0, bus.waddr} < LP_DEPTH);
    assign w_rd_in  = ({1'b0, bus.raddr} < LP_DEPTH);
    assign w_wr_oor = bus.we && !w_wr_in;
    assign w_rd_oor = bus.re && !w_rd_in;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            CLEAR: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == LP_LAST) begin
                    w_state_nx = IDLE;
                end
            end
            IDLE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = CLEAR;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Write port belongs to the sweep while clearing, to the user otherwise.
    always_comb begin
        w_core_we    = 1'b0;
        w_core_waddr = bus.waddr;
        w_core_wdata = bus.wdata;
        if (!i_rst) begin
            if (w_idle) begin
                w_core_we = bus.we && w_wr_in;
            end else begin
                w_core_we    = 1'b1;
                w_core_waddr = r_cnt[ADDR_W-1:0];
                w_core_wdata = INIT_VAL;
            end
        end
    end

    assign w_core_re    = w_idle && bus.re && w_rd_in;
    assign w_core_rzero = w_idle && w_rd_oor;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_idle) begin
            r_rvalid <= bus.re;
            r_err    <= w_wr_oor || w_rd_oor;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= bus.we || bus.re;
        end
    end

    ram_sdp_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_re    (w_core_re),
        .i_rzero (w_core_rzero),
        .i_raddr (bus.raddr),
        .o_rdata (bus.rdata)
    );

    assign bus.rvalid = r_rvalid;
    assign bus.busy   = (r_state == CLEAR);
    assign bus.err    = r_err;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Three RAM configurations share one stimulus stream and are checked
// against a per-instance behavioural model every cycle.
module tb_ram_sdp_clr;
    import mem_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       s_we = 1'b0, s_re = 1'b0;
    logic [3:0] s_waddr = '0, s_raddr = '0;
    logic [7:0] s_wdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) b0 ();
    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) b1 ();
    ram_sdp_clr_if #(.DATA_W(8), .ADDR_W(4)) b2 ();

    assign b0.we = s_we; assign b0.waddr = s_waddr; assign b0.wdata = s_wdata;
    assign b0.re = s_re; assign b0.raddr = s_raddr;
    assign b1.we = s_we; assign b1.waddr = s_waddr; assign b1.wdata = s_wdata;
    assign b1.re = s_re; assign b1.raddr = s_raddr;
    assign b2.we = s_we; assign b2.waddr = s_waddr; assign b2.wdata = s_wdata;
    assign b2.re = s_re; assign b2.raddr = s_raddr;

    ram_sdp_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'hA5), .RDW_MODE(RDW_READ_FIRST))
        dut0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
    ram_sdp_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(8'hA5), .RDW_MODE(RDW_WRITE_THROUGH))
        dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
    ram_sdp_clr #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'hA5), .RDW_MODE(RDW_READ_FIRST))
        dut2 (.i_clk(clk), .i_rst(rst), .bus(b2.slave));

    logic [7:0] a_rdata  [NDUT];
    logic       a_rvalid [NDUT];
    logic       a_busy   [NDUT];
    logic       a_err    [NDUT];

    assign a_rdata[0] = b0.rdata; assign a_rvalid[0] = b0.rvalid;
    assign a_busy[0]  = b0.busy;  assign a_err[0]    = b0.err;
    assign a_rdata[1] = b1.rdata; assign a_rvalid[1] = b1.rvalid;
    assign a_busy[1]  = b1.busy;  assign a_err[1]    = b1.err;
    assign a_rdata[2] = b2.rdata; assign a_rvalid[2] = b2.rvalid;
    assign a_busy[2]  = b2.busy;  assign a_err[2]    = b2.err;

    function automatic int dep(input int d);
        return (d == 2) ? 12 : 16;
    endfunction

    function automatic bit wthru(input int d);
        return (d == 1);
    endfunction

    // Model: sweep is "cycles left to clear"; reads see memory before this edge's write.
    logic [7:0] m_mem   [NDUT][16];
    int         m_left  [NDUT];
    logic [7:0] e_rdata [NDUT];
    logic       e_rvalid[NDUT];
    logic       e_err   [NDUT];

    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                m_left[d]   <= dep(d);
                e_rdata[d]  <= 8'h00;
                e_rvalid[d] <= 1'b0;
                e_err[d]    <= 1'b0;
            end else if (m_left[d] > 0) begin
                m_mem[d][dep(d) - m_left[d]] <= 8'hA5;
                m_left[d]   <= m_left[d] - 1;
                e_err[d]    <= s_we | s_re;
                e_rvalid[d] <= 1'b0;
            end else begin
                e_err[d]    <= (s_we && int'(s_waddr) >= dep(d)) || (s_re && int'(s_raddr) >= dep(d));
                e_rvalid[d] <= s_re;
                if (s_re) begin
                    if (int'(s_raddr) >= dep(d))
                        e_rdata[d] <= 8'h00;
                    else if (wthru(d) && s_we && s_waddr == s_raddr)
                        e_rdata[d] <= s_wdata;
                    else
                        e_rdata[d] <= m_mem[d][s_raddr];
                end
                if (s_we && int'(s_waddr) < dep(d))
                    m_mem[d][s_waddr] <= s_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bcnt [NDUT];
        rst = 1'b1; s_we = 1'b0; s_re = 1'b0;
        tick();
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (a_rdata[d] !== 8'h00 || a_rvalid[d] !== 1'b0 || a_busy[d] !== 1'b1 || a_err[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: got rd=%h v=%b busy=%b err=%b want rd=00 v=0 busy=1 err=0",
                         d, a_rdata[d], a_rvalid[d], a_busy[d], a_err[d]);
            end
            bcnt[d] = 1;
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                if (a_busy[d] === 1'b1) bcnt[d]++;
                n_cmp++;
                if (a_rdata[d] !== e_rdata[d] || a_rvalid[d] !== e_rvalid[d] ||
                    a_busy[d] !== (m_left[d] > 0) || a_err[d] !== e_err[d]) begin
                    n_bad++;
                    $display("FAIL sweep dut%0d c%0d: got rd=%h v=%b busy=%b err=%b want rd=%h v=%b busy=%b err=%b",
                             d, c, a_rdata[d], a_rvalid[d], a_busy[d], a_err[d],
                             e_rdata[d], e_rvalid[d], m_left[d] > 0, e_err[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (bcnt[d] != dep(d)) begin
                n_bad++;
                $display("FAIL busy_len dut%0d: got %0d want %0d", d, bcnt[d], dep(d));
            end
        end
    endtask

    task automatic test_clear_readback();
        for (int a = 0; a < 16; a++) begin
            s_re = 1'b1; s_raddr = 4'(a);
            tick();
            n_cmp++;
            if (a_rdata[0] !== 8'hA5 || a_rvalid[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL clear_rd addr%0d: got rd=%h v=%b want rd=a5 v=1", a, a_rdata[0], a_rvalid[0]);
            end
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (a_rdata[d] !== e_rdata[d] || a_rvalid[d] !== e_rvalid[d] || a_err[d] !== e_err[d]) begin
                    n_bad++;
                    $display("FAIL clear_model dut%0d addr%0d: got rd=%h v=%b err=%b want rd=%h v=%b err=%b",
                             d, a, a_rdata[d], a_rvalid[d], a_err[d], e_rdata[d], e_rvalid[d], e_err[d]);
                end
            end
        end
        s_re = 1'b0;
        tick();
        n_cmp++;
        if (a_rvalid[0] !== 1'b0 || a_rdata[0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL idle_hold: got rd=%h v=%b want rd=a5 v=0", a_rdata[0], a_rvalid[0]);
        end
    endtask

    task automatic test_write_read_random();
        int a;
        for (int k = 0; k < 16; k++) begin
            s_we = 1'b1; s_waddr = 4'(k); s_wdata = 8'(2 * k);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (a_err[d] !== e_err[d] || a_rvalid[d] !== e_rvalid[d]) begin
                    n_bad++;
                    $display("FAIL wr_fill dut%0d k%0d: got err=%b v=%b want err=%b v=%b",
                             d, k, a_err[d], a_rvalid[d], e_err[d], e_rvalid[d]);
                end
            end
        end
        s_we = 1'b0;
        void'($urandom(35));
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom_range(15, 0));
            s_re = 1'b1; s_raddr = 4'(a);
            tick();
            n_cmp++;
            if (a_rdata[0] !== 8'(2 * a) || a_rvalid[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL rand_rd addr%0d: got rd=%h v=%b want rd=%h v=1", a, a_rdata[0], a_rvalid[0], 8'(2 * a));
            end
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (a_rdata[d] !== e_rdata[d] || a_rvalid[d] !== e_rvalid[d] || a_err[d] !== e_err[d]) begin
                    n_bad++;
                    $display("FAIL rand_model dut%0d addr%0d: got rd=%h v=%b err=%b want rd=%h v=%b err=%b",
                             d, a, a_rdata[d], a_rvalid[d], a_err[d], e_rdata[d], e_rvalid[d], e_err[d]);
                end
            end
        end
        s_re = 1'b0;
        tick();
    endtask

    task automatic test_rdw();
        s_we = 1'b1; s_waddr = 4'd3; s_wdata = 8'h11; s_re = 1'b0;
        tick();
        s_wdata = 8'h22; s_re = 1'b1; s_raddr = 4'd3;
        tick();
        n_cmp++;
        if (a_rdata[0] !== 8'h11 || a_rdata[1] !== 8'h22 || a_rvalid[0] !== 1'b1 || a_rvalid[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL rdw_same: got rf=%h wt=%h v=%b%b want rf=11 wt=22 v=11",
                     a_rdata[0], a_rdata[1], a_rvalid[0], a_rvalid[1]);
        end
        s_we = 1'b0;
        tick();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (a_rdata[d] !== 8'h22 || a_rdata[d] !== e_rdata[d] || a_rvalid[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL rdw_after dut%0d: got rd=%h v=%b want rd=22 v=1", d, a_rdata[d], a_rvalid[d]);
            end
        end
        s_re = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        s_we = 1'b1; s_waddr = 4'd13; s_wdata = 8'h5A;
        tick();
        n_cmp++;
        if (a_err[2] !== 1'b1 || a_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_wr_err: got d12=%b d16=%b want d12=1 d16=0", a_err[2], a_err[0]);
        end
        s_we = 1'b0; s_re = 1'b1; s_raddr = 4'd13;
        tick();
        n_cmp++;
        if (a_rdata[2] !== 8'h00 || a_rvalid[2] !== 1'b1 || a_err[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_rd: got rd=%h v=%b err=%b want rd=00 v=1 err=1", a_rdata[2], a_rvalid[2], a_err[2]);
        end
        n_cmp++;
        if (a_rdata[0] !== 8'h5A || a_err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL inrange_13: got rd=%h err=%b want rd=5a err=0", a_rdata[0], a_err[0]);
        end
        s_we = 1'b1; s_waddr = 4'd14; s_re = 1'b1; s_raddr = 4'd15;
        tick();
        s_we = 1'b0; s_re = 1'b0;
        tick();
        n_cmp++;
        if (a_err[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_single_pulse: got err=%b want 0", a_err[2]);
        end
        for (int a = 0; a < 12; a++) begin
            s_re = 1'b1; s_raddr = 4'(a);
            tick();
            n_cmp++;
            if (a_rdata[2] !== e_rdata[2] || a_rvalid[2] !== 1'b1 || a_err[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL oor_keep addr%0d: got rd=%h v=%b err=%b want rd=%h v=1 err=0",
                         a, a_rdata[2], a_rvalid[2], a_err[2], e_rdata[2]);
            end
        end
        s_re = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_sweep();
        int  bcnt;
        bit  done;
        s_we = 1'b1; s_waddr = 4'd5; s_wdata = 8'h77; s_re = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bcnt = 1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (a_busy[0] === 1'b1) bcnt++;
            else done = 1'b1;
            if (done) s_we = 1'b0;
            n_cmp++;
            if (a_err[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep_err c%0d: got %b want 1", c, a_err[0]);
            end
            for (int d = 0; d < NDUT; d++) begin
                n_cmp++;
                if (a_busy[d] !== (m_left[d] > 0) || a_err[d] !== e_err[d] || a_rvalid[d] !== e_rvalid[d]) begin
                    n_bad++;
                    $display("FAIL sweep2_model dut%0d c%0d: got busy=%b err=%b v=%b want busy=%b err=%b v=%b",
                             d, c, a_busy[d], a_err[d], a_rvalid[d], m_left[d] > 0, e_err[d], e_rvalid[d]);
                end
            end
        end
        s_we = 1'b0;
        n_cmp++;
        if (!done || bcnt != 16) begin
            n_bad++;
            $display("FAIL busy_len2: got %0d (ended=%b) want 16", bcnt, done);
        end
        for (int a = 0; a < 16; a++) begin
            s_re = 1'b1; s_raddr = 4'(a);
            tick();
            n_cmp++;
            if (a_rdata[0] !== 8'hA5 || a_rvalid[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL reclear_rd addr%0d: got rd=%h v=%b want rd=a5 v=1", a, a_rdata[0], a_rvalid[0]);
            end
            n_cmp++;
            if (a_rdata[2] !== e_rdata[2] || a_rvalid[2] !== e_rvalid[2]) begin
                n_bad++;
                $display("FAIL reclear_d12 addr%0d: got rd=%h v=%b want rd=%h v=%b",
                         a, a_rdata[2], a_rvalid[2], e_rdata[2], e_rvalid[2]);
            end
        end
        s_re = 1'b0;
        tick();
    endtask

    task automatic test_rst_with_read();
        s_re = 1'b1; s_raddr = 4'd2; rst = 1'b1;
        tick();
        rst = 1'b0; s_re = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (a_rvalid[d] !== 1'b0 || a_rdata[d] !== 8'h00 || a_busy[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_rd dut%0d: got v=%b rd=%h busy=%b want v=0 rd=00 busy=1",
                         d, a_rvalid[d], a_rdata[d], a_busy[d]);
            end
        end
        for (int c = 0; c < 20; c++) tick();
        for (int d = 0; d < NDUT; d++) begin
            n_cmp++;
            if (a_busy[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_rd_done dut%0d: got busy=%b want 0", d, a_busy[d]);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_clear_readback();
        test_write_read_random();
        test_rdw();
        test_out_of_range();
        test_rst_mid_sweep();
        test_rst_with_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
